// File: rtl/header_detacher_pkg.sv
// Shared constants, state encoding and beat layout for the header detacher.
package header_detacher_pkg;

  localparam int unsigned DATA_W               = 128;
  localparam int unsigned KEEP_W               = DATA_W / 8;
  localparam int unsigned USER_W               = 32;
  localparam int unsigned BYTES_PER_BEAT       = DATA_W / 8;
  localparam int unsigned HEADER_BEATS         = 2;
  localparam int unsigned ROLLOVER_BYTE_OFFSET = 28;
  localparam int unsigned ROLLOVER_BYTES       = USER_W / 8;
  // Beat carrying the rollover field and the byte lane it starts on.
  localparam int unsigned ROLLOVER_BEAT        = ROLLOVER_BYTE_OFFSET / BYTES_PER_BEAT;
  localparam int unsigned ROLLOVER_LANE        = ROLLOVER_BYTE_OFFSET % BYTES_PER_BEAT;

  typedef enum logic [1:0] {
    HDR0    = 2'd0,
    HDR1    = 2'd1,
    PAYLOAD = 2'd2
  } state_e;

  // One buffered output beat; user travels with the beat so frames never mix.
  typedef struct packed {
    logic [USER_W-1:0] user;
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  localparam int unsigned BEAT_W = $bits(beat_t);

  // Big-endian rollover time: first wire byte lands in the top byte of the result.
  function automatic logic [USER_W-1:0] rollover_of(input logic [DATA_W-1:0] d);
    logic [USER_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ROLLOVER_BYTES; i++) begin
      r[USER_W-1-8*i -: 8] = d[8*(ROLLOVER_LANE+i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/header_detacher_skid.sv
// Two-entry skid buffer: registered output stage plus one overflow slot,
// with a registered input ready that drops only when both slots are occupied.
module header_detacher_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             ready_q,      ready_d;
  logic             push;
  logic             pop;

  // Next-state of both slots; the output slot refills from the skid slot first
  // to preserve ordering.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    push         = in_valid_i & ready_q;
    pop          = out_valid_q & out_ready_i;

    if (!out_valid_q || pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = push;
        if (push) begin
          skid_data_d = in_data_i;
        end
      end else begin
        out_valid_d = push;
        if (push) begin
          out_data_d = in_data_i;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end

    ready_d = ~(out_valid_d & skid_valid_d);
  end

  // Slot registers; reset empties the buffer and clears the visible payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/header_detacher.sv
// Strips the two-beat Time Tagger header from each frame, forwarding payload
// beats with the frame's rollover time on tuser.
module header_detacher
  import header_detacher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,

  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [USER_W-1:0]     m_axis_tuser
);

  // Only the 128-bit datapath with a fixed header layout is implemented.
  if (DATA_WIDTH != DATA_W) begin : g_bad_data_width
    $error("header_detacher: DATA_WIDTH must be 128");
  end
  if (KEEP_WIDTH != KEEP_W) begin : g_bad_keep_width
    $error("header_detacher: KEEP_WIDTH must be DATA_WIDTH/8");
  end
  if (HEADER_BEATS != 2 || ROLLOVER_BEAT != HEADER_BEATS - 1) begin : g_bad_header
    $error("header_detacher: rollover field must sit in the last of two header beats");
  end

  state_e            state_q, state_d;
  logic [USER_W-1:0] rollover_q, rollover_d;
  logic              run_q;
  logic              in_hs;
  logic              skid_in_valid;
  logic              skid_ready;
  beat_t             in_beat;
  beat_t             out_beat;

  // Header beats are always accepted; payload beats follow buffer space.
  assign s_axis_tready = run_q & ((state_q != PAYLOAD) | skid_ready);
  assign in_hs         = s_axis_tvalid & s_axis_tready;
  assign skid_in_valid = s_axis_tvalid & run_q & (state_q == PAYLOAD);

  // Payload beat as pushed into the buffer, tagged with this frame's rollover.
  always_comb begin
    in_beat      = '0;
    in_beat.user = rollover_q;
    in_beat.data = s_axis_tdata;
    in_beat.keep = s_axis_tkeep;
    in_beat.last = s_axis_tlast;
  end

  // Frame tracking: skip two header beats, latch rollover, forward until tlast.
  always_comb begin
    state_d    = state_q;
    rollover_d = rollover_q;
    unique case (state_q)
      HDR0: begin
        if (in_hs) begin
          state_d = s_axis_tlast ? HDR0 : HDR1;
        end
      end
      HDR1: begin
        if (in_hs) begin
          if (s_axis_tlast) begin
            state_d = HDR0;
          end else begin
            state_d    = PAYLOAD;
            rollover_d = rollover_of(s_axis_tdata);
          end
        end
      end
      PAYLOAD: begin
        if (in_hs && s_axis_tlast) begin
          state_d = HDR0;
        end
      end
      default: state_d = HDR0;
    endcase
  end

  // State, rollover and run-enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HDR0;
      rollover_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rollover_q <= rollover_d;
      run_q      <= 1'b1;
    end
  end

  header_detacher_skid #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (skid_in_valid),
    .in_ready_o (skid_ready),
    .in_data_i  (in_beat),
    .out_valid_o(m_axis_tvalid),
    .out_ready_i(m_axis_tready),
    .out_data_o (out_beat)
  );

  assign m_axis_tdata = out_beat.data;
  assign m_axis_tkeep = out_beat.keep;
  assign m_axis_tlast = out_beat.last;
  assign m_axis_tuser = out_beat.user;

endmodule

// File: tb/tb_header_detacher.sv
// Directed, table-driven and randomized-gap bench for header_detacher.
module tb_header_detacher;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_tvalid;
  logic         s_tready;
  logic [127:0] s_tdata;
  logic [15:0]  s_tkeep;
  logic         s_tlast;
  logic         m_tvalid;
  logic         m_tready;
  logic [127:0] m_tdata;
  logic [15:0]  m_tkeep;
  logic         m_tlast;
  logic [31:0]  m_tuser;

  header_detacher #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
    logic [31:0]  user;
  } exp_t;

  typedef struct {
    int          nb;
    logic [31:0] ro;
    int          exp_out;
  } vec_t;

  exp_t         exp_q[$];
  exp_t         e;
  int           n_checks  = 0;
  int           n_pass    = 0;
  int           out_count = 0;
  int           rdy_mode  = 0;
  int           first_low;
  int           base;
  int           exp_total;
  logic [177:0] bus;
  logic [177:0] prev_bus;
  bit           prev_pending = 1'b0;
  vec_t         tbl[6];

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic summary_and_finish();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  // Output monitor: scoreboard compare on every accepted beat, stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      bus = {m_tvalid, m_tlast, m_tkeep, m_tuser, m_tdata};
      if (prev_pending) chk("hold_stable", bus, prev_bus);
      if (m_tvalid && m_tready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, e);
        end
      end
      prev_pending = m_tvalid && !m_tready;
      prev_bus     = bus;
    end
  end

  // Output ready generator: 0 = always ready, 1 = random 70%, 2 = held low.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 99) < 70);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Sends one frame; payload beats (index >= 2) are queued as expected output.
  task automatic send_frame(input int nb, input logic [31:0] ro, input int fid,
                            input int gap_pct, input bit end_last);
    for (int b = 0; b < nb; b++) begin
      logic [127:0] d;
      logic [15:0]  k;
      logic         l;
      int           waitc;
      bit           acc;
      if (gap_pct > 0) begin
        while ($urandom_range(0, 99) < gap_pct) begin
          s_tvalid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      d[15:0]  = fid[15:0];
      d[23:16] = b[7:0];
      if (b == 1) begin
        d[103:96]  = ro[31:24];
        d[111:104] = ro[23:16];
        d[119:112] = ro[15:8];
        d[127:120] = ro[7:0];
      end
      l = end_last && (b == nb - 1);
      k = l ? (16'hFFFF >> (fid % 16)) : 16'hFFFF;
      if (b >= 2) exp_q.push_back({d, k, l, ro});
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      waitc    = 0;
      acc      = 1'b0;
      while (!acc) begin
        @(negedge clk);
        if (s_tready) acc = 1'b1;
        @(posedge clk);
        #1;
        if (!acc) begin
          waitc++;
          if (waitc > 2000) begin
            chk("s_tready_timeout", 0, 1);
            summary_and_finish();
          end
        end
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Waits for the scoreboard to empty, then idles a few cycles to catch extra beats.
  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(posedge clk);
      c++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;

    tbl[0] = '{4, 32'h12345678, 2};
    tbl[1] = '{2, 32'hDEAD0001, 0};
    tbl[2] = '{3, 32'hCAFE0003, 1};
    tbl[3] = '{1, 32'h01020304, 0};
    tbl[4] = '{5, 32'h0BADF00D, 3};
    tbl[5] = '{3, 32'hFFFFFFFF, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tlast",  m_tlast,  0);
    chk("rst_m_tdata",  m_tdata,  0);
    chk("rst_m_tkeep",  m_tkeep,  0);
    chk("rst_m_tuser",  m_tuser,  0);
    chk("rst_s_tready", s_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("s_tready_before_edge", s_tready, 0);
    @(posedge clk);
    #1;
    chk("s_tready_first_edge", s_tready, 1);

    // Table-driven frames with output always ready
    for (int i = 0; i < 6; i++) begin
      base = out_count;
      send_frame(tbl[i].nb, tbl[i].ro, i, 0, 1'b1);
      drain();
      chk($sformatf("frame%0d_out_count", i), out_count - base, tbl[i].exp_out);
    end

    // Output stall of 5 clk in the middle of a 10-beat payload
    base      = out_count;
    first_low = -1;
    fork
      send_frame(12, 32'h0000C0DE, 20, 0, 1'b1);
      begin
        repeat (5) @(posedge clk);
        rdy_mode = 2;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (!s_tready && first_low < 0) first_low = k;
        end
        rdy_mode = 0;
      end
    join
    drain();
    chk("stall_backpressure_2clk", (first_low >= 0) && (first_low < 2), 1);
    chk("stall_out_count", out_count - base, 10);

    // Next frame's header enters while the previous frame's last beat is stalled
    base     = out_count;
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    fork
      begin
        send_frame(3, 32'hAAAA0001, 30, 0, 1'b1);
        send_frame(4, 32'hBBBB0002, 31, 0, 1'b1);
      end
      begin
        repeat (8) @(posedge clk);
        rdy_mode = 0;
      end
    join
    drain();
    chk("overlap_out_count", out_count - base, 3);

    // Reset pulse with buffered payload, then a clean frame
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_frame(4, 32'h55667788, 40, 0, 1'b0);
    @(negedge clk);
    chk("pre_rst_buffered", m_tvalid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_m_tvalid", m_tvalid, 0);
    chk("rst_async_s_tready", s_tready, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    base = out_count;
    send_frame(3, 32'h0F0F1234, 41, 0, 1'b1);
    drain();
    chk("post_rst_out_count", out_count - base, 1);

    // Random valid/ready gaps over 1000 frames
    base      = out_count;
    exp_total = 0;
    rdy_mode  = 1;
    for (int f = 0; f < 1000; f++) begin
      int          nb;
      logic [31:0] ro;
      nb = $urandom_range(1, 6);
      ro = $urandom();
      send_frame(nb, ro, 100 + f, 30, 1'b1);
      if (nb > 2) exp_total += nb - 2;
    end
    drain();
    chk("random_out_count", out_count - base, exp_total);
    rdy_mode = 0;

    summary_and_finish();
  end

endmodule
